// File: rtl/ldst_unit.sv
// Memory stage of the Buraq-mini RV32IM pipeline: one data-memory access per instruction
// over req/gnt/rvalid, with byte-lane store alignment and load extraction/extension.
module ldst_unit #(
    parameter int DataWidth    = 32,
    parameter int AddrWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic                    ieu_mem_ren,
    input  logic                    ieu_mem_wen,
    input  logic                    ieu_memtoreg,
    input  logic                    ieu_regfile_en,
    input  logic [RegAddrWidth-1:0] ieu_addr_dst,
    input  logic [2:0]              ieu_func3,
    input  logic [DataWidth-1:0]    ieu_mem_addr,
    input  logic [DataWidth-1:0]    ieu_store_data,
    input  logic [DataWidth-1:0]    ieu_alu_result_dealy,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [3:0]              dmem_be,
    output logic [AddrWidth-1:0]    dmem_addr,
    output logic [DataWidth-1:0]    dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    ldst_stall,
    output logic                    ldst_regfile_en,
    output logic                    ldst_memtoreg,
    output logic [RegAddrWidth-1:0] ldst_addr_dst,
    output logic [DataWidth-1:0]    ldst_mem_result,
    output logic [DataWidth-1:0]    ldst_alu_result,
    output logic                    ldst_misaligned
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

    state_t               state;
    logic [1:0]           byte_off;
    logic                 mem_op;
    logic                 misaligned;
    logic                 aligned_op;
    logic                 complete;
    logic [DataWidth-1:0] shifted;
    logic [DataWidth-1:0] load_ext;

    assign byte_off   = ieu_mem_addr[1:0];
    assign mem_op     = ieu_mem_ren | ieu_mem_wen;
    // Misalignment is only judged when a new instruction is first seen.
    assign misaligned = (state == IDLE) && mem_op &&
                        (((ieu_func3[1:0] == 2'b01) && byte_off[0]) ||
                         ((ieu_func3[1:0] == 2'b10) && (byte_off != 2'b00)));
    assign aligned_op = mem_op && !misaligned;

    assign dmem_req  = ((state == IDLE) && aligned_op) || (state == WAIT_GNT);
    assign dmem_we   = dmem_req && ieu_mem_wen;
    assign dmem_addr = {ieu_mem_addr[AddrWidth-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = ieu_store_data;
        case (ieu_func3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << byte_off;
                dmem_wdata = {4{ieu_store_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << byte_off;
                dmem_wdata = {2{ieu_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (ieu_func3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        complete = 1'b1;
        case (state)
            IDLE:        complete = !aligned_op || (ieu_mem_wen && dmem_gnt);
            WAIT_GNT:    complete = ieu_mem_wen && dmem_gnt;
            WAIT_RVALID: complete = dmem_rvalid;
            default:     complete = 1'b1;
        endcase
    end

    assign ldst_stall = !complete;

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state           <= IDLE;
            ldst_regfile_en <= 1'b0;
            ldst_memtoreg   <= 1'b0;
            ldst_addr_dst   <= '0;
            ldst_mem_result <= '0;
            ldst_alu_result <= '0;
            ldst_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (aligned_op && !(ieu_mem_wen && dmem_gnt))
                        state <= dmem_gnt ? WAIT_RVALID : WAIT_GNT;
                WAIT_GNT:
                    if (dmem_gnt) state <= ieu_mem_wen ? IDLE : WAIT_RVALID;
                WAIT_RVALID:
                    if (dmem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A stalled cycle becomes a bubble so writeback sees each result once.
            if (ldst_stall) begin
                ldst_regfile_en <= 1'b0;
                ldst_misaligned <= 1'b0;
            end else begin
                ldst_regfile_en <= ieu_regfile_en && !misaligned;
                ldst_misaligned <= misaligned;
                ldst_memtoreg   <= ieu_memtoreg;
                ldst_addr_dst   <= ieu_addr_dst;
                ldst_alu_result <= ieu_alu_result_dealy;
                if (state == WAIT_RVALID) ldst_mem_result <= load_ext;
            end
        end
    end

endmodule
